pipeline_stall_controller: RTL

Sequencing controller for the 5-stage ARM pipeline. It merges the combinational hazard-detect signal, the EXE-stage branch-taken signal and the MEM-stage SRAM handshake into per-stage freeze, flush and bubble controls. It runs a small FSM that holds the pipeline across multi-cycle SRAM accesses, with a timeout guard, and keeps saturating stall and flush performance counters. It sits beside the hazard detection unit and drives the enable and clear inputs of the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.

---
 rtl/arm_pipe_pkg.sv | 17 +
 rtl/sat_counter.sv | 39 +++
 rtl/pipeline_stall_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM pipeline sequencing logic: FSM state
// encoding and the default sizing of the stall controller.
package arm_pipe_pkg;

   // Controller states: free-running pipeline, or holding for an SRAM access.
   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } pipe_state_e;

   // Default maximum number of frozen cycles for one SRAM access.
   localparam int DEF_MEM_TIMEOUT = 16;

   // Default width of the stall/flush performance counters.
   localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a synchronous clear that beats increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX_V = {W{1'b1}};
   localparam logic [W-1:0] ONE_V = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] count_d;
   logic [W-1:0] count_q;

   // Next count: clear first, otherwise step until the all-ones ceiling.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != MAX_V)) begin
         count_d = count_q + ONE_V;
      end
   end

   // Count register, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline sequencing controller: merges hazard, branch and SRAM handshake
// into per-stage freeze/flush/bubble controls, holds the pipeline across
// multi-cycle SRAM accesses with a timeout guard, and counts stall/flush
// cycles.
//
// Stage controls are Mealy outputs (same-cycle response). Priority:
// memory stall > branch > hazard. During a memory stall branch and hazard
// inputs are ignored because the frozen instructions present them again
// in the release cycle. The sram handshake is level based: sram_ready=1
// in a cycle completes the access requested by mem_req in that cycle or
// the one being waited on.
module pipeline_stall_controller
   import arm_pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard_detected,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             sram_ready,
   input  logic             clr_counters,
   output logic             freeze_pc,
   output logic             freeze_if_id,
   output logic             freeze_id_exe,
   output logic             freeze_exe_mem,
   output logic             flush_if_id,
   output logic             bubble_id_exe,
   output logic             bubble_mem_wb,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic             dbg_state
);

   localparam int WCW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCW-1:0] TIMEOUT_V = WCW'(MEM_TIMEOUT);
   localparam logic [WCW-1:0] ONE_V     = WCW'(1);

   pipe_state_e    state_d;
   pipe_state_e    state_q;
   logic [WCW-1:0] wait_cnt_d;
   logic [WCW-1:0] wait_cnt_q;
   logic           mem_error_d;
   logic           mem_error_q;
   logic           mem_stall;

   // Next-state, frozen-cycle count and timeout flag; also flags whether
   // this cycle is a memory stall.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_error_d = mem_error_q;
      mem_stall   = 1'b0;
      case (state_q)
         ST_RUN: begin
            // A zero-wait access (ready with the request) never freezes.
            if (mem_req && !sram_ready) begin
               mem_stall  = 1'b1;
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = ONE_V;
            end
         end
         ST_MEM_WAIT: begin
            if (sram_ready) begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q < TIMEOUT_V) begin
               mem_stall  = 1'b1;
               wait_cnt_d = wait_cnt_q + ONE_V;
            end else begin
               // Forced release: unfreeze as if data arrived, remember it.
               state_d     = ST_RUN;
               wait_cnt_d  = '0;
               mem_error_d = 1'b1;
            end
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // FSM state, wait counter and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         mem_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_error_q <= mem_error_d;
      end
   end

   // Stage-control decode by priority; everything is forced low in reset.
   always_comb begin
      freeze_pc      = 1'b0;
      freeze_if_id   = 1'b0;
      freeze_id_exe  = 1'b0;
      freeze_exe_mem = 1'b0;
      flush_if_id    = 1'b0;
      bubble_id_exe  = 1'b0;
      bubble_mem_wb  = 1'b0;
      if (rst) begin
         freeze_pc = 1'b0;
      end else if (mem_stall) begin
         freeze_pc      = 1'b1;
         freeze_if_id   = 1'b1;
         freeze_id_exe  = 1'b1;
         freeze_exe_mem = 1'b1;
         bubble_mem_wb  = 1'b1;
      end else if (branch_taken) begin
         // PC stays unfrozen so it loads the branch target.
         flush_if_id   = 1'b1;
         bubble_id_exe = 1'b1;
      end else if (hazard_detected) begin
         freeze_pc     = 1'b1;
         freeze_if_id  = 1'b1;
         bubble_id_exe = 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_counters),
      .inc   (freeze_pc),
      .count (stall_count)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_counters),
      .inc   (flush_if_id),
      .count (flush_count)
   );

   assign mem_error = mem_error_q;
   assign dbg_state = state_q;

endmodule
